saph_pack_stream: RTL
=====================

# saph_pack_stream

Accumulates a stream of fixed-width numbers, each reduced to a per-beat bit width by keeping its most significant bits, into packed output words, LSB-first. It is the stage downstream of the per-field packer: it owns the running bit position and word assembly, and it emits complete or flushed words over a valid/ready handshake to the framebuffer/memory write path. A field never straddles two words; a field that does not fit closes the current word.

## Interface
- `word_width`, 32, packed output word width; must be at least `unpack_width`.
- `unpack_width`, 8, input number width, 2+.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  `unpack_width`  unpacked number.
- `in_width`  in  `$clog2(unpack_width+1)`  field width in bits; 0 means no bits; values above `unpack_width` are clamped to `unpack_width`.
- `in_last`  in  1  flush the word after this beat.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  output word consumed when `out_valid && out_ready`.
- `out_data`  out  `word_width`  packed word; bits at and above `out_bits` are 0.
- `out_bits`  out  `$clog2(word_width+1)`  number of valid bits in `out_data`.
- `out_last`  out  1  word was closed by `in_last`.

## Operation
- Internal state: accumulator `acc` (`word_width`), position `pos`, output register (`out_*`), flag `pending`.
- Field = `in_data >> (unpack_width - w)`, where w is the clamped width, placed at `acc` bit `pos`.
- Output slot free = `!out_valid || out_ready`.
- `in_ready` = slot free && `!pending`.
- On an accepted beat:
  - Fit (`pos + w < word_width`): `acc |= field << pos`, `pos += w`.
  - Exact (`pos + w == word_width`): load the output with `acc | field << pos`, bits `word_width`; clear `acc` and `pos`.
  - Overflow (`pos + w > word_width`): load the output with `acc`, bits `pos`, last 0; then `acc = field`, `pos = w`.
  - `in_last` with a fit: load the output with `acc | field << pos`, bits `pos + w`, last 1; clear `acc` and `pos`. If `pos + w == 0`, nothing is emitted.
  - `in_last` with an exact fit: as exact, with last 1.
  - `in_last` with an overflow: perform the overflow, then set `pending`.
- While `pending`: on the next cycle in which the slot is free, load the output with `acc`, bits `pos`, last 1; clear `acc`, `pos` and `pending`.
- A beat with w = 0 and no `in_last` changes nothing but is still accepted.
- Loading the output sets `out_valid`. A handshake with no new load clears `out_valid`. The `out_*` registers hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_bits` 0, `out_last` 0, `in_ready` 1; `acc`, `pos` and `pending` are 0.
- Reset mid-word discards the partial word without emitting it.
- `in_ready` is combinational from `out_valid`, `out_ready` and `pending`; there is no combinational path from `in_*` to `out_*`.
- Latency is 1 cycle from the closing beat's handshake edge to `out_valid`.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- An overflow with `in_last` costs one extra cycle: `in_ready` is low for at least that cycle.
- A simultaneous output handshake and new load in the same cycle keeps `out_valid` at 1 with the new data.

## Test plan
- Test configuration: `word_width`=16, `unpack_width`=8.
- Four beats at w=4, `in_data` 0xA5, 0x3C, 0xF0, 0x12, `out_ready`=1 -> one cycle after the 4th beat: `out_data`=0x1F3A, `out_bits`=16, `out_last`=0, for exactly one cycle.
- Three beats at w=6, `in_data` 0xFF, 0x80, 0x04 -> on the 3rd beat the output is `out_data`=0x083F, `out_bits`=12. A following w=0 beat with `in_last` then emits 0x0001, bits 6, last 1.
- Beats at w=7: 0xFE, 0x02, then 0x80 with `in_last` -> the first output is 0x00FF, bits 14, last 0; the next cycle gives 0x0040, bits 7, last 1. `in_ready` is low in the cycle between.
- Backpressure: `out_ready`=0 with a full word held -> `in_ready`=0 and `out_*` stable for 5 cycles. Raising `out_ready` gives the handshake and `in_ready`=1 in the same cycle. A w=15 beat is treated as w=8.
- Assert `rst` asynchronously after two w=4 beats -> outputs return to reset values immediately. Four fresh w=4 beats of 0x10 then yield 0x1111, with no residue from before reset.

Source files
------------

// File: rtl/saph_pack_stream.sv
// Packs MSB-kept input fields LSB-first into words; a word closes when full, on overflow or on in_last.
// One cycle from the closing beat to out_valid; in_ready drops while the output is stalled or a flush is pending.
`timescale 1ns/1ps
module saph_pack_stream #(
  parameter int word_width   = 32,
  parameter int unpack_width = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [unpack_width-1:0]           in_data,
  input  logic [$clog2(unpack_width+1)-1:0] in_width,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [word_width-1:0]             out_data,
  output logic [$clog2(word_width+1)-1:0]   out_bits,
  output logic                              out_last
);
  localparam int WW = $clog2(unpack_width + 1);
  localparam int PW = $clog2(word_width + 1);
  // pos + w can reach almost twice the word width, so one extra bit is kept
  localparam int SW = PW + 1;
  localparam logic [WW-1:0] W_MAX  = WW'(unpack_width);
  localparam logic [SW-1:0] S_FULL = SW'(word_width);

  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [PW-1:0]         bits;
    logic [word_width-1:0] data;
  } out_t;

  logic [word_width-1:0]   acc_q, acc_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic                    pend_q, pend_d;
  out_t                    out_q, out_d;

  logic                    slot_free;
  logic                    beat;
  logic [WW-1:0]           w;
  logic [unpack_width-1:0] field_n;
  logic [word_width-1:0]   field;
  logic [word_width-1:0]   placed;
  logic [SW-1:0]           sum;

  assign slot_free = !out_q.vld || out_ready;
  assign in_ready  = slot_free && !pend_q;
  assign beat      = in_valid && in_ready;

  assign w       = (in_width > W_MAX) ? W_MAX : in_width;
  assign field_n = in_data >> (W_MAX - w);
  assign field   = word_width'(field_n);
  assign placed  = field << pos_q;
  assign sum     = SW'(pos_q) + SW'(w);

  always_comb begin
    acc_d  = acc_q;
    pos_d  = pos_q;
    pend_d = pend_q;
    out_d  = out_q;
    if (out_ready) begin
      out_d.vld = 1'b0;
    end

    if (pend_q) begin
      // Second half of an overflow that carried in_last: flush the carried field
      if (slot_free) begin
        out_d.vld  = 1'b1;
        out_d.last = 1'b1;
        out_d.bits = pos_q;
        out_d.data = acc_q;
        acc_d      = '0;
        pos_d      = '0;
        pend_d     = 1'b0;
      end
    end else if (beat) begin
      if (sum < S_FULL) begin
        if (in_last) begin
          if (sum != '0) begin
            out_d.vld  = 1'b1;
            out_d.last = 1'b1;
            out_d.bits = PW'(sum);
            out_d.data = acc_q | placed;
          end
          acc_d = '0;
          pos_d = '0;
        end else begin
          acc_d = acc_q | placed;
          pos_d = PW'(sum);
        end
      end else if (sum == S_FULL) begin
        out_d.vld  = 1'b1;
        out_d.last = in_last;
        out_d.bits = PW'(sum);
        out_d.data = acc_q | placed;
        acc_d      = '0;
        pos_d      = '0;
      end else begin
        // Fields never straddle words: close the current word and start over with this field
        out_d.vld  = 1'b1;
        out_d.last = 1'b0;
        out_d.bits = pos_q;
        out_d.data = acc_q;
        acc_d      = field;
        pos_d      = PW'(w);
        pend_d     = in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      pos_q  <= '0;
      pend_q <= 1'b0;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      pos_q  <= pos_d;
      pend_q <= pend_d;
      out_q  <= out_d;
    end
  end

  assign out_valid = out_q.vld;
  assign out_data  = out_q.data;
  assign out_bits  = out_q.bits;
  assign out_last  = out_q.last;

endmodule
